artec_axis2axi_wr: RTL
======================

Name: artec_axis2axi_wr

Overview:
- AXI4 write master that sits directly downstream of the DMA header/pass stage.
- Consumes the AXIS command stream (start address and byte count) and the AXIS data stream that stage emits.
- Converts each command into one or more AXI4 INCR write bursts; tracks B responses and reports idle/error status to the DMA control block.

Parameters:
- ADDR_W, 32, AXI address width; f_saddr width.
- DATA_W, 64, AXI/AXIS data width; bytes per beat = DATA_W/8 = 1<<PKG_ADDRESS_SHIFT.
- MAX_BURST, 16, maximum beats per burst (1..256).
- MAX_OUTSTANDING, 4, maximum AW issued without a B response (1..15).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active-low
- clear_i  in  1  synchronous soft clear
- s_cmd_tvalid / s_cmd_tready  in/out  1/1  command handshake
- s_cmd_tdata  in  $bits(axis_cmd_t)  {f_type, f_btt[22:0], f_saddr[ADDR_W-1:0]}
- s_data_tvalid / s_data_tready  in/out  1/1  data handshake
- s_data_tdata  in  DATA_W  write data
- m_awaddr  out  ADDR_W  burst address
- m_awlen  out  8  beats-1
- m_awsize  out  3  constant PKG_ADDRESS_SHIFT
- m_awburst  out  2  constant 2'b01 (INCR)
- m_awvalid / m_awready  out/in  1/1
- m_wdata  out  DATA_W  = s_data_tdata
- m_wstrb  out  DATA_W/8  all ones
- m_wlast  out  1  last beat of burst
- m_wvalid / m_wready  out/in  1/1
- m_bresp  in  2
- m_bvalid / m_bready  in/out  1/1
- idle_o  out  1  FSM IDLE and no outstanding bursts
- err_o  out  1  sticky BRESP error
- beat_cnt_o  out  32  W beats transferred (see optional feature)

Behaviour:
- Reset: FSM IDLE; all counters 0; awvalid = wvalid = wlast = err_o = 0; idle_o = 1; beat_cnt_o = 0; m_bready = 1 always.
- FSM states IDLE, CALC, ADDR, DATA:
  - IDLE: s_cmd_tready = 1. On handshake: latch addr = f_saddr and rem = f_btt >> PKG_ADDRESS_SHIFT (low bits ignored). If rem == 0, stay IDLE (command dropped); otherwise go to CALC.
  - CALC (one cycle): len = min(rem, MAX_BURST, (4096 - addr[11:0]) >> PKG_ADDRESS_SHIFT), registered, so bursts never cross a 4 KB boundary. Go to ADDR. m_awvalid therefore rises 2 cycles after command accept.
  - ADDR: m_awvalid = (outstanding < MAX_OUTSTANDING). Hold awaddr/awlen stable until awready. On handshake go to DATA.
  - DATA: m_wvalid = s_data_tvalid; s_data_tready = m_wready; both are combinational pass-through with no buffering. A beat counter runs 0..len-1; m_wlast = (beat == len-1). On the last handshake: addr += len << PKG_ADDRESS_SHIFT; rem -= len. Go to IDLE if rem == 0, else CALC.
- s_data_tready = 0 outside DATA; s_cmd_tready = 0 outside IDLE.
- Outstanding counter:
  - +1 on AW handshake, -1 on B handshake; simultaneous events leave it unchanged.
  - It never exceeds MAX_OUTSTANDING.
  - A B response arriving at count 0 is a protocol violation; the count saturates at 0.
- err_o is set the cycle after a B handshake with bresp != 2'b00. It stays set until clear_i or reset. Transfers continue after an error.
- idle_o = (state == IDLE) && (outstanding == 0).
- clear_i:
  - In IDLE, CALC or ADDR: FSM returns to IDLE immediately, with no AW issued.
  - In DATA: the current burst completes (AXI rule) and the FSM then goes to IDLE; remaining rem is discarded.
  - err_o and beat_cnt_o are cleared immediately.
  - Outstanding is not cleared; it drains via B responses.
- Reset mid-burst is asynchronous and returns everything to reset values. The system must also reset the slave.

Optional Feature:
- Macro: ARTEC_AXI_WR_STATS_EN.
- Defined: 32-bit beat_cnt_o increments on each W handshake, wraps at 2^32-1 to 0, and is cleared by clear_i.
- Undefined: no counter logic; beat_cnt_o tied to 0.

Decomposition:
- artec_dma_pkg holds: axis_cmd_t, PKG_ADDRESS_SHIFT, AXI_RESP_OKAY, AXI_BURST_INCR, and the 4 KB page constant.
- One natural sub-module: artec_axi_burst_len. Purely combinational, it computes len from (addr, rem, MAX_BURST) and is reused by a future read-side block.
- The FSM and counters stay in the top module.

Test Plan (DATA_W=64, MAX_BURST=16, MAX_OUTSTANDING=2):
- saddr=0x1000, btt=256 -> AW 0x1000 len 15 then AW 0x1080 len 15; wlast on beats 16 and 32; idle_o=1 after both B.
- saddr=0x0FF0, btt=64 -> AW 0x0FF0 awlen=1, AW 0x1000 awlen=5; no burst crosses 0x1000.
- btt=0 -> command accepted in 1 cycle, no AW/W activity, idle_o stays 1.
- bresp=2'b10 on second B of a 3-burst command -> err_o=1 one cycle later, third burst still completes; clear_i -> err_o=0.
- btt=512 with bvalid held low -> only 2 AW issued, 3rd awvalid low until first B handshake.
- m_wready toggling 1/0 each cycle with s_data_tvalid high -> s_data_tready mirrors wready; 32 beats delivered in order, no loss or duplication.

Source files
------------

// File: rtl/artec_dma_pkg.sv
// Shared types and constants for the artec DMA AXI side: command payload,
// beat/byte shift, AXI encodings and 4 KB page geometry.
package artec_dma_pkg;

  localparam int unsigned PKG_ADDR_W        = 32;
  localparam int unsigned PKG_BTT_W         = 23;
  localparam int unsigned PKG_ADDRESS_SHIFT = 3;
  localparam int unsigned PKG_PAGE_BYTES    = 4096;
  localparam int unsigned PKG_PAGE_W        = 12;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic                  f_type;
    logic [PKG_BTT_W-1:0]  f_btt;
    logic [PKG_ADDR_W-1:0] f_saddr;
  } axis_cmd_t;

endpackage

// File: rtl/artec_axi_burst_len.sv
// Burst length = min(remaining beats, MAX_BURST, beats left in the 4 KB page).
// Purely combinational; shared by the read and write masters.
module artec_axi_burst_len
  import artec_dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned REM_W     = 20,
  parameter int unsigned LEN_W     = 9
) (
  input  logic [PKG_PAGE_W-PKG_ADDRESS_SHIFT-1:0] page_beat_off,
  input  logic [REM_W-1:0]                        rem,
  output logic [LEN_W-1:0]                        len_c
);

  localparam int unsigned PB_W = PKG_PAGE_W - PKG_ADDRESS_SHIFT + 1;

  logic [PB_W-1:0]  page_beats;
  logic [REM_W-1:0] cap;

  always_comb begin
    page_beats = PB_W'(PKG_PAGE_BYTES >> PKG_ADDRESS_SHIFT) - PB_W'(page_beat_off);
    cap        = REM_W'(page_beats);
    if (REM_W'(MAX_BURST) < cap) cap = REM_W'(MAX_BURST);
    if (rem < cap) cap = rem;
    len_c = LEN_W'(cap);
  end

endmodule

// File: rtl/artec_axis2axi_wr.sv
// AXIS command/data to AXI4 INCR write bursts with B tracking and status.
// Optional beat statistics counter enabled by ARTEC_AXI_WR_STATS_EN.
module artec_axis2axi_wr
  import artec_dma_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear_i,
  input  logic                s_cmd_tvalid,
  output logic                s_cmd_tready,
  input  axis_cmd_t           s_cmd_tdata,
  input  logic                s_data_tvalid,
  output logic                s_data_tready,
  input  logic [DATA_W-1:0]   s_data_tdata,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                idle_o,
  output logic                err_o,
  output logic [31:0]         beat_cnt_o
);

  localparam int unsigned REM_W  = PKG_BTT_W - PKG_ADDRESS_SHIFT;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned OUT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_ADDR = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [REM_W-1:0]  rem, cmd_rem;
  logic [LEN_W-1:0]  len, len_c;
  logic [BEAT_W-1:0] beat;
  logic [OUT_W-1:0]  outstanding;
  logic              clr_pend;
  logic              aw_hs, w_hs, b_hs, last_beat;
  logic              unused_cmd;

  assign cmd_rem    = REM_W'(s_cmd_tdata.f_btt >> PKG_ADDRESS_SHIFT);
  assign unused_cmd = ^{s_cmd_tdata.f_type, s_cmd_tdata.f_btt[PKG_ADDRESS_SHIFT-1:0]};
  assign last_beat  = (LEN_W'(beat) == len - LEN_W'(1));
  assign aw_hs      = m_awvalid && m_awready;
  assign w_hs       = m_wvalid && m_wready;
  assign b_hs       = m_bvalid && m_bready;

  assign m_awaddr  = addr;
  assign m_awlen   = 8'(len - LEN_W'(1));
  assign m_awsize  = 3'(PKG_ADDRESS_SHIFT);
  assign m_awburst = AXI_BURST_INCR;
  assign m_wdata   = s_data_tdata;
  assign m_wstrb   = '1;
  assign m_bready  = 1'b1;
  assign idle_o    = (state == S_IDLE) && (outstanding == '0);

  artec_axi_burst_len #(
    .MAX_BURST (MAX_BURST),
    .REM_W     (REM_W),
    .LEN_W     (LEN_W)
  ) u_burst_len (
    .page_beat_off (addr[PKG_PAGE_W-1:PKG_ADDRESS_SHIFT]),
    .rem           (rem),
    .len_c         (len_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A clear during DATA only takes effect once the open burst has finished
  always_comb begin
    state_nxt     = state;
    s_cmd_tready  = 1'b0;
    s_data_tready = 1'b0;
    m_awvalid     = 1'b0;
    m_wvalid      = 1'b0;
    m_wlast       = 1'b0;
    case (state)
      S_IDLE: begin
        s_cmd_tready = !clear_i;
        if (s_cmd_tvalid && !clear_i && cmd_rem != '0) state_nxt = S_CALC;
      end
      S_CALC: state_nxt = clear_i ? S_IDLE : S_ADDR;
      S_ADDR: begin
        m_awvalid = !clear_i && (outstanding < OUT_W'(MAX_OUTSTANDING));
        if (clear_i)                      state_nxt = S_IDLE;
        else if (m_awvalid && m_awready)  state_nxt = S_DATA;
      end
      S_DATA: begin
        m_wvalid      = s_data_tvalid;
        s_data_tready = m_wready;
        m_wlast       = last_beat;
        if (s_data_tvalid && m_wready && last_beat)
          state_nxt = (clr_pend || clear_i || rem == REM_W'(len)) ? S_IDLE : S_CALC;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr     <= '0;
      rem      <= '0;
      len      <= '0;
      beat     <= '0;
      clr_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (s_cmd_tready && s_cmd_tvalid) begin
          addr <= ADDR_W'(s_cmd_tdata.f_saddr);
          rem  <= cmd_rem;
        end
        S_CALC: len <= len_c;
        S_DATA: if (w_hs) begin
          if (last_beat) begin
            beat <= '0;
            addr <= addr + (ADDR_W'(len) << PKG_ADDRESS_SHIFT);
            rem  <= rem - REM_W'(len);
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: ;
      endcase
      clr_pend <= (state == S_DATA) && (clr_pend || clear_i) && !(w_hs && last_beat);
    end
  end

  // Bursts in flight; a B at zero is a slave protocol error and is ignored
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - OUT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       err_o <= 1'b0;
    else if (clear_i)                                err_o <= 1'b0;
    else if (b_hs && m_bresp != AXI_RESP_OKAY)       err_o <= 1'b1;
  end

`ifdef ARTEC_AXI_WR_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        beat_cnt_o <= '0;
    else if (clear_i) beat_cnt_o <= '0;
    else if (w_hs)    beat_cnt_o <= beat_cnt_o + 32'd1;
  end
`else
  assign beat_cnt_o = '0;
`endif

endmodule
